sisc_ctrl_mc: RTL and testbench

- Second-generation SISC control FSM: variable-length multi-cycle sequencing.
- Each opcode visits only the states it needs, and fetch/memory accesses stall on a ready handshake.
- HLT enters a synthesizable HALT state.
- Sits between IR/status register and the datapath (RF, ALU, PC, IR, memory port); also counts retired instructions.

---
 rtl/sisc_pkg.sv | 47 ++++
 rtl/sisc_ctrl_mc_if.sv | 39 +++
 rtl/sisc_retire_cnt.sv | 20 ++
 rtl/sisc_ctrl_mc.sv | 161 ++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the multi-cycle SISC controller: state
// encoding, opcode values and ALU operation encodings.
package sisc_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP = 4'd0,
        OP_LOD  = 4'd1,
        OP_STR  = 4'd2,
        OP_SWP  = 4'd3,
        OP_BRA  = 4'd4,
        OP_BRR  = 4'd5,
        OP_BNE  = 4'd6,
        OP_BNR  = 4'd7,
        OP_ALU  = 4'd8,
        OP_HLT  = 4'd15
    } opcode_t;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;

    // Any of the four conditional branch opcodes.
    function automatic logic is_branch(input opcode_t op);
        return (op == OP_BRA) || (op == OP_BRR) || (op == OP_BNE) || (op == OP_BNR);
    endfunction

    // Branch-if-not-equal variants invert the mask test.
    function automatic logic is_neg_branch(input opcode_t op);
        return (op == OP_BNE) || (op == OP_BNR);
    endfunction

    // PC-relative variants select the relative target.
    function automatic logic is_rel_branch(input opcode_t op);
        return (op == OP_BRR) || (op == OP_BNR);
    endfunction

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// Control bus between the SISC controller and IR/status/datapath.
// The controller uses the master side; the datapath/IR side uses slave.
interface sisc_ctrl_mc_if #(
    parameter int OP_W  = 4,
    parameter int MM_W  = 4,
    parameter int CNT_W = 16
);
    logic [OP_W-1:0]  opcode;
    logic [MM_W-1:0]  mm;
    logic [MM_W-1:0]  stat;
    logic             mem_rdy;

    logic             rf_we;
    logic             wb_sel;
    logic [1:0]       alu_op;
    logic             rb_sel;
    logic             br_sel;
    logic             pc_rst;
    logic             pc_write;
    logic             pc_sel;
    logic             ir_load;
    logic             mem_req;
    logic             mem_we;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mm, stat, mem_rdy,
        output rf_we, wb_sel, alu_op, rb_sel, br_sel, pc_rst, pc_write,
               pc_sel, ir_load, mem_req, mem_we, halted, instr_count
    );

    modport slave (
        output opcode, mm, stat, mem_rdy,
        input  rf_we, wb_sel, alu_op, rb_sel, br_sel, pc_rst, pc_write,
               pc_sel, ir_load, mem_req, mem_we, halted, instr_count
    );

endinterface

// File: rtl/sisc_retire_cnt.sv
// Retired-instruction counter: wraps naturally at 2^CNT_W, cleared
// asynchronously together with the controller state.
module sisc_retire_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per retiring cycle; reset wins over increment.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            count <= '0;
        else if (inc)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/sisc_ctrl_mc.sv
// Multi-cycle SISC control FSM. Each opcode walks only the states it
// needs; FETCH and MEM wait on mem_rdy. All controls are decoded
// combinationally from the registered state and the IR/status inputs.
module sisc_ctrl_mc
    import sisc_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int MM_W   = 4,
    parameter int CNT_W  = 16,
    parameter int AM_IMM = 8
) (
    input  logic          clk,
    input  logic          rst_f,
    sisc_ctrl_mc_if.master bus
);

    state_t          state, nxt;
    opcode_t         op;
    logic [OP_W-1:0] opc;
    logic [MM_W-1:0] mm_v;
    logic            br_hit;
    logic            taken;
    logic            retire;

    logic       rf_we, wb_sel, rb_sel, br_sel, pc_rst, pc_write, pc_sel;
    logic       ir_load, mem_req, mem_we, halted;
    logic [1:0] alu_op;

    assign opc    = bus.opcode;
    assign op     = opcode_t'(opc[3:0]);
    assign mm_v   = bus.mm;
    assign br_hit = |(mm_v & bus.stat);
    assign taken  = is_neg_branch(op) ? !br_hit : br_hit;

    // State register; async reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            state <= S_RESET;
        else
            state <= nxt;
    end

    // Next-state, control decode and retire strobe.
    always_comb begin
        nxt      = state;
        retire   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = ALU_ADDR;
        rb_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        ir_load  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_RESET: begin
                pc_rst = 1'b1;
                nxt    = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_rdy) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    pc_sel   = 1'b0;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_branch(op)) begin
                    br_sel   = is_rel_branch(op);
                    pc_write = taken;
                    pc_sel   = taken;
                    retire   = 1'b1;
                    nxt      = S_FETCH;
                end else begin
                    case (op)
                        OP_HLT: begin
                            retire = 1'b1;
                            nxt    = S_HALT;
                        end
                        OP_ALU, OP_LOD, OP_STR, OP_SWP: nxt = S_EXEC;
                        // NOOP and undefined opcodes retire immediately.
                        default: begin
                            retire = 1'b1;
                            nxt    = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ALU: begin
                        alu_op = (mm_v == MM_W'(AM_IMM)) ? ALU_RI : ALU_RR;
                        nxt    = S_WB;
                    end
                    OP_LOD, OP_STR: begin
                        alu_op = ALU_ADDR;
                        nxt    = S_MEM;
                    end
                    OP_SWP: begin
                        rb_sel = 1'b1;
                        alu_op = ALU_RR;
                        nxt    = S_WB;
                    end
                    default: nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                alu_op  = ALU_ADDR;
                if (op == OP_STR) begin
                    mem_we = 1'b1;
                    rb_sel = 1'b1;
                end
                if (bus.mem_rdy) begin
                    if (op == OP_LOD) begin
                        nxt = S_WB;
                    end else begin
                        retire = 1'b1;
                        nxt    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = (op == OP_LOD);
                rb_sel = (op == OP_SWP);
                retire = 1'b1;
                nxt    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: nxt = S_RESET;
        endcase
    end

    sisc_retire_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_f (rst_f),
        .inc   (retire),
        .count (bus.instr_count)
    );

    assign bus.rf_we    = rf_we;
    assign bus.wb_sel   = wb_sel;
    assign bus.alu_op   = alu_op;
    assign bus.rb_sel   = rb_sel;
    assign bus.br_sel   = br_sel;
    assign bus.pc_rst   = pc_rst;
    assign bus.pc_write = pc_write;
    assign bus.pc_sel   = pc_sel;
    assign bus.ir_load  = ir_load;
    assign bus.mem_req  = mem_req;
    assign bus.mem_we   = mem_we;
    assign bus.halted   = halted;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed bench for sisc_ctrl_mc: a per-cycle vector table for the
// instruction mix, then hand sequences for HALT and async reset pulses.
// A second instance with a 2-bit counter tracks retire-count wrap.
module tb_sisc_ctrl_mc;

    logic clk;
    logic rst_f;

    sisc_ctrl_mc_if #(.OP_W(4), .MM_W(4), .CNT_W(16)) bus ();
    sisc_ctrl_mc_if #(.OP_W(4), .MM_W(4), .CNT_W(2))  bus2 ();

    sisc_ctrl_mc #(.OP_W(4), .MM_W(4), .CNT_W(16), .AM_IMM(8)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    sisc_ctrl_mc #(.OP_W(4), .MM_W(4), .CNT_W(2), .AM_IMM(8)) dut_w (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus2)
    );

    assign bus2.opcode  = bus.opcode;
    assign bus2.mm      = bus.mm;
    assign bus2.stat    = bus.stat;
    assign bus2.mem_rdy = bus.mem_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rf_we, wb_sel, alu_op[1:0], rb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, mem_req, mem_we}
    localparam logic [11:0] IDLE  = 12'b0_0_10_0_0_0_0_0_0_0_0;
    localparam logic [11:0] RST   = 12'b0_0_10_0_0_1_0_0_0_0_0;
    localparam logic [11:0] FWAIT = 12'b0_0_10_0_0_0_0_0_0_1_0;
    localparam logic [11:0] FGO   = 12'b0_0_10_0_0_0_1_0_1_1_0;
    localparam logic [11:0] EXRI  = 12'b0_0_01_0_0_0_0_0_0_0_0;
    localparam logic [11:0] EXRR  = 12'b0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [11:0] EXSWP = 12'b0_0_00_1_0_0_0_0_0_0_0;
    localparam logic [11:0] MRD   = 12'b0_0_10_0_0_0_0_0_0_1_0;
    localparam logic [11:0] MWR   = 12'b0_0_10_1_0_0_0_0_0_1_1;
    localparam logic [11:0] WBALU = 12'b1_0_10_0_0_0_0_0_0_0_0;
    localparam logic [11:0] WBLOD = 12'b1_1_10_0_0_0_0_0_0_0_0;
    localparam logic [11:0] WBSWP = 12'b1_0_10_1_0_0_0_0_0_0_0;
    localparam logic [11:0] BRRT  = 12'b0_0_10_0_1_0_1_1_0_0_0;
    localparam logic [11:0] BABT  = 12'b0_0_10_0_0_0_1_1_0_0_0;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [3:0]  st;
        logic        rdy;
        logic [11:0] ctrl;
        logic        halt;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [11:0] act_ctrl;
    assign act_ctrl = {bus.rf_we, bus.wb_sel, bus.alu_op, bus.rb_sel, bus.br_sel,
                       bus.pc_rst, bus.pc_write, bus.pc_sel, bus.ir_load,
                       bus.mem_req, bus.mem_we};

    task automatic add(input logic r, input logic [3:0] op, input logic [3:0] mm,
                       input logic [3:0] st, input logic rdy, input logic [11:0] c,
                       input logic h, input logic [15:0] n);
        vec_t v;
        v.rst = r; v.op = op; v.mm = mm; v.st = st; v.rdy = rdy;
        v.ctrl = c; v.halt = h; v.cnt = n;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare all observable outputs against one expectation.
    task automatic chk_all(input string tag, input logic [11:0] c, input logic h,
                           input logic [15:0] n);
        chk({tag, " ctrl"},  32'(act_ctrl), 32'(c));
        chk({tag, " halted"}, 32'(bus.halted), 32'(h));
        chk({tag, " count"}, 32'(bus.instr_count), 32'(n));
        chk({tag, " count_w"}, 32'(bus2.instr_count), 32'(n[1:0]));
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] mm,
                         input logic [3:0] st, input logic rdy);
        bus.opcode = op; bus.mm = mm; bus.stat = st; bus.mem_rdy = rdy;
    endtask

    initial begin
        rst_f = 1'b1;
        drive(4'd0, 4'd0, 4'd0, 1'b0);
        #1 rst_f = 1'b0;

        // reset held three cycles, then released (still RESET that cycle)
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, RST, 0, 0);
        add(1, 0, 0, 0, 0, RST, 0, 0);
        // ALU immediate
        add(1, 8, 8, 0, 1, FGO,   0, 0);
        add(1, 8, 8, 0, 1, IDLE,  0, 0);
        add(1, 8, 8, 0, 0, EXRI,  0, 0);
        add(1, 8, 8, 0, 1, WBALU, 0, 0);
        // LOD: fetch stalls 3 cycles, MEM waits 2 cycles
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, FWAIT, 0, 1);
        add(1, 1, 0, 0, 1, FGO,   0, 1);
        add(1, 1, 0, 0, 0, IDLE,  0, 1);
        add(1, 1, 0, 0, 1, IDLE,  0, 1);
        add(1, 1, 0, 0, 0, MRD,   0, 1);
        add(1, 1, 0, 0, 0, MRD,   0, 1);
        add(1, 1, 0, 0, 1, MRD,   0, 1);
        add(1, 1, 0, 0, 0, WBLOD, 0, 1);
        // STR with one MEM wait
        add(1, 2, 0, 0, 1, FGO,   0, 2);
        add(1, 2, 0, 0, 0, IDLE,  0, 2);
        add(1, 2, 0, 0, 0, IDLE,  0, 2);
        add(1, 2, 0, 0, 0, MWR,   0, 2);
        add(1, 2, 0, 0, 1, MWR,   0, 2);
        // SWP
        add(1, 3, 0, 0, 1, FGO,   0, 3);
        add(1, 3, 0, 0, 0, IDLE,  0, 3);
        add(1, 3, 0, 0, 0, EXSWP, 0, 3);
        add(1, 3, 0, 0, 0, WBSWP, 0, 3);
        // branches
        add(1, 5, 4'b0010, 4'b0010, 1, FGO,  0, 4);
        add(1, 5, 4'b0010, 4'b0010, 0, BRRT, 0, 4);
        add(1, 6, 4'b0010, 4'b0010, 1, FGO,  0, 5);
        add(1, 6, 4'b0010, 4'b0010, 0, IDLE, 0, 5);
        add(1, 6, 4'b0010, 4'b0100, 1, FGO,  0, 6);
        add(1, 6, 4'b0010, 4'b0100, 0, BABT, 0, 6);
        add(1, 4, 4'b0001, 4'b0100, 1, FGO,  0, 7);
        add(1, 4, 4'b0001, 4'b0100, 0, IDLE, 0, 7);
        add(1, 7, 4'b1000, 4'b0001, 1, FGO,  0, 8);
        add(1, 7, 4'b1000, 4'b0001, 0, BRRT, 0, 8);
        // ALU reg-reg
        add(1, 8, 3, 0, 1, FGO,   0, 9);
        add(1, 8, 3, 0, 0, IDLE,  0, 9);
        add(1, 8, 3, 0, 0, EXRR,  0, 9);
        add(1, 8, 3, 0, 0, WBALU, 0, 9);
        // undefined opcode, NOOP
        add(1, 12, 0, 0, 1, FGO,  0, 10);
        add(1, 12, 0, 0, 1, IDLE, 0, 10);
        add(1, 0,  0, 0, 1, FGO,  0, 11);
        add(1, 0,  0, 0, 0, IDLE, 0, 11);
        // HLT
        add(1, 15, 0, 0, 1, FGO,  0, 12);
        add(1, 15, 0, 0, 1, IDLE, 0, 12);
        add(1, 1,  0, 0, 1, IDLE, 1, 13);
        add(1, 2,  0, 0, 0, IDLE, 1, 13);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_f = tbl[i].rst;
            drive(tbl[i].op, tbl[i].mm, tbl[i].st, tbl[i].rdy);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].halt, tbl[i].cnt);
        end

        // HALT holds for 20 cycles regardless of inputs
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(4'($urandom_range(0, 15)), 4'd0, 4'd0, 1'($urandom_range(0, 1)));
            #1;
            chk_all($sformatf("halt%0d", i), IDLE, 1'b1, 16'd13);
        end

        // reset pulse mid-HALT takes effect immediately
        @(negedge clk);
        #2 rst_f = 1'b0;
        #1 chk_all("rst_halt", RST, 1'b0, 16'd0);
        @(negedge clk);
        rst_f = 1'b1;
        #1 chk_all("rst_rel", RST, 1'b0, 16'd0);

        // NOOP, then LOD stuck in MEM wait, then reset pulse
        @(negedge clk); drive(4'd0, 0, 0, 1'b1); #1 chk_all("nf", FGO, 0, 0);
        @(negedge clk); #1 chk_all("nd", IDLE, 0, 0);
        @(negedge clk); drive(4'd1, 0, 0, 1'b1); #1 chk_all("lf", FGO, 0, 1);
        @(negedge clk); drive(4'd1, 0, 0, 1'b0); #1 chk_all("ld", IDLE, 0, 1);
        @(negedge clk); #1 chk_all("le", IDLE, 0, 1);
        @(negedge clk); #1 chk_all("lm", MRD, 0, 1);
        #2 rst_f = 1'b0;
        #1 chk_all("rst_mem", RST, 1'b0, 16'd0);
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk); drive(4'd0, 0, 0, 1'b0); #1 chk_all("post_f", FWAIT, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
